sync_fifo: RTL and testbench

- Single-clock, synchronous first-in/first-out buffer for 32-bit data words.
- Writes and reads are accepted on rising clk edges when the block is enabled.
- FULL and EMPTY status flags are provided.
- Used as a generic rate-decoupling buffer between a producer and a consumer in the same clock domain.

---
 rtl/fifo_pkg.sv | 8 +
 rtl/fifo_mem.sv | 29 ++
 rtl/sync_fifo.sv | 84 ++++++++
 tb/tb_sync_fifo.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared sizing constants for the synchronous FIFO
package fifo_pkg;

  localparam int FIFO_WIDTH = 32;
  localparam int FIFO_DEPTH = 8;
  localparam int FIFO_AW    = $clog2(FIFO_DEPTH);

endpackage : fifo_pkg

// File: rtl/fifo_mem.sv
// rtl/fifo_mem.sv - DEPTH x WIDTH register array, one sync write port, one read port
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int WIDTH = FIFO_WIDTH,
  parameter int DEPTH = FIFO_DEPTH,
  parameter int AW    = FIFO_AW
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage is never reset; the owner tracks which entries are valid.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read port is a plain array lookup; the caller registers the result.
  assign rdata = mem[raddr];

endmodule : fifo_mem

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with registered read data and FULL/EMPTY flags
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int WIDTH = FIFO_WIDTH,
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             EN,
  input  logic             RD,
  input  logic             WR,
  output logic             EMPTY,
  output logic             FULL,
  output logic [WIDTH-1:0] data_out
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [WIDTH-1:0] mem_rdata;
  logic             wr_ok;
  logic             rd_ok;

  // Acceptance is qualified by the registered flags, so a write into a full
  // FIFO or a read from an empty one never disturbs state.
  assign wr_ok = EN & WR & ~FULL;
  assign rd_ok = EN & RD & ~EMPTY;

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (wr_ok),
    .waddr (wr_ptr),
    .wdata (data_in),
    .raddr (rd_ptr),
    .rdata (mem_rdata)
  );

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Occupancy moves only when exactly one side is accepted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else begin
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Read data is captured only on accepted reads and otherwise holds.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_out <= '0;
    end else if (rd_ok) begin
      data_out <= mem_rdata;
    end
  end

  // Flags decode the registered count, so no input reaches an output.
  assign EMPTY = (count == '0);
  assign FULL  = (count == FULL_CNT);

endmodule : sync_fifo

// File: tb/tb_sync_fifo.sv
// tb/tb_sync_fifo.sv - scoreboard bench for sync_fifo
module tb_sync_fifo;

  localparam int DEPTH = 8;

  logic        clk;
  logic        reset;
  logic [31:0] data_in;
  logic        EN;
  logic        RD;
  logic        WR;
  logic        EMPTY;
  logic        FULL;
  logic [31:0] data_out;

  int          n_checks;
  int          n_fail;
  int          model_count;
  logic [31:0] sb [$];

  sync_fifo dut (
    .clk      (clk),
    .reset    (reset),
    .data_in  (data_in),
    .EN       (EN),
    .RD       (RD),
    .WR       (WR),
    .EMPTY    (EMPTY),
    .FULL     (FULL),
    .data_out (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle at the falling edge, predict acceptance from the model,
  // advance through the rising edge and return at the next falling edge.
  task automatic drive_cycle(input logic en, input logic rd, input logic wr,
                             input logic [31:0] din,
                             output logic rd_acc, output logic [31:0] exp_d);
    logic wr_acc;
    wr_acc = en && wr && (model_count < DEPTH);
    rd_acc = en && rd && (model_count > 0);
    exp_d  = 32'h0;
    EN = en; RD = rd; WR = wr; data_in = din;
    if (rd_acc) exp_d = sb.pop_front();
    if (wr_acc) sb.push_back(din);
    @(posedge clk);
    @(negedge clk);
    if (wr_acc && !rd_acc) model_count++;
    if (rd_acc && !wr_acc) model_count--;
    RD = 1'b0; WR = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; EN = 1'b0; RD = 1'b0; WR = 1'b0; data_in = '0;
    model_count = 0;
    repeat (5) @(negedge clk);
    n_checks++;
    if (EMPTY !== 1'b1) begin $display("FAIL reset_empty got=%b exp=1", EMPTY); n_fail++; end
    n_checks++;
    if (FULL !== 1'b0) begin $display("FAIL reset_full got=%b exp=0", FULL); n_fail++; end
    n_checks++;
    if (data_out !== 32'h0) begin $display("FAIL reset_dout got=%h exp=0", data_out); n_fail++; end
    reset = 1'b1;
    EN = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic_order();
    logic acc; logic [31:0] e;
    for (int i = 1; i <= 4; i++) drive_cycle(1'b1, 1'b0, 1'b1, 32'(i), acc, e);
    for (int i = 1; i <= 4; i++) begin
      drive_cycle(1'b1, 1'b1, 1'b0, 32'h0, acc, e);
      n_checks++;
      if (!acc || e !== 32'(i) || data_out !== e) begin
        $display("FAIL basic_order[%0d] got=%h exp=%h", i, data_out, 32'(i)); n_fail++;
      end
    end
    n_checks++;
    if (EMPTY !== 1'b1) begin $display("FAIL basic_empty got=%b exp=1", EMPTY); n_fail++; end
  endtask

  task automatic test_full();
    logic acc; logic [31:0] e;
    for (int i = 0; i < 8; i++) drive_cycle(1'b1, 1'b0, 1'b1, 32'h10 + 32'(i), acc, e);
    n_checks++;
    if (FULL !== 1'b1 || EMPTY !== 1'b0) begin
      $display("FAIL full_set got=%b/%b exp=1/0", FULL, EMPTY); n_fail++;
    end
    drive_cycle(1'b1, 1'b0, 1'b1, 32'hFF, acc, e);
    n_checks++;
    if (FULL !== 1'b1) begin $display("FAIL full_hold got=%b exp=1", FULL); n_fail++; end
    for (int i = 0; i < 8; i++) begin
      drive_cycle(1'b1, 1'b1, 1'b0, 32'h0, acc, e);
      n_checks++;
      if (!acc || data_out !== e || data_out !== 32'h10 + 32'(i)) begin
        $display("FAIL full_read[%0d] got=%h exp=%h", i, data_out, 32'h10 + 32'(i)); n_fail++;
      end
    end
    n_checks++;
    if (EMPTY !== 1'b1 || FULL !== 1'b0) begin
      $display("FAIL full_drained got=%b/%b exp=1/0", EMPTY, FULL); n_fail++;
    end
  endtask

  task automatic test_empty_read();
    logic acc; logic [31:0] e;
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b1, 1'b1, 1'b0, 32'h0, acc, e);
      n_checks++;
      if (data_out !== 32'h17 || EMPTY !== 1'b1) begin
        $display("FAIL empty_read_hold[%0d] got=%h/%b exp=17/1", i, data_out, EMPTY); n_fail++;
      end
    end
    drive_cycle(1'b1, 1'b0, 1'b1, 32'hA5, acc, e);
    drive_cycle(1'b1, 1'b1, 1'b0, 32'h0, acc, e);
    n_checks++;
    if (!acc || data_out !== e || data_out !== 32'hA5) begin
      $display("FAIL empty_then_a5 got=%h exp=a5", data_out); n_fail++;
    end
  endtask

  task automatic test_simultaneous_wrap();
    logic acc; logic [31:0] e;
    for (int i = 0; i < 3; i++) drive_cycle(1'b1, 1'b0, 1'b1, 32'h100 + 32'(i), acc, e);
    for (int i = 0; i < 12; i++) begin
      drive_cycle(1'b1, 1'b1, 1'b1, 32'h103 + 32'(i), acc, e);
      n_checks++;
      if (!acc || data_out !== e || data_out !== 32'h100 + 32'(i) ||
          EMPTY !== 1'b0 || FULL !== 1'b0 || model_count != 3) begin
        $display("FAIL simul[%0d] got=%h/%b/%b exp=%h/0/0", i, data_out, EMPTY, FULL,
                 32'h100 + 32'(i)); n_fail++;
      end
    end
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b1, 1'b1, 1'b0, 32'h0, acc, e);
      n_checks++;
      if (!acc || data_out !== e || data_out !== 32'h10C + 32'(i)) begin
        $display("FAIL simul_drain[%0d] got=%h exp=%h", i, data_out, 32'h10C + 32'(i)); n_fail++;
      end
    end
    n_checks++;
    if (EMPTY !== 1'b1) begin $display("FAIL simul_empty got=%b exp=1", EMPTY); n_fail++; end
  endtask

  task automatic test_enable_gating();
    logic acc; logic [31:0] e;
    logic [31:0] held;
    drive_cycle(1'b1, 1'b0, 1'b1, 32'h200, acc, e);
    drive_cycle(1'b1, 1'b0, 1'b1, 32'h201, acc, e);
    held = 32'h10E;
    for (int i = 0; i < 4; i++) begin
      drive_cycle(1'b0, 1'b1, 1'b1, 32'hDEAD_0000 + 32'(i), acc, e);
      n_checks++;
      if (data_out !== held || EMPTY !== 1'b0 || FULL !== 1'b0) begin
        $display("FAIL en_hold[%0d] got=%h/%b/%b exp=%h/0/0", i, data_out, EMPTY, FULL, held);
        n_fail++;
      end
    end
    for (int i = 0; i < 2; i++) begin
      drive_cycle(1'b1, 1'b1, 1'b0, 32'h0, acc, e);
      n_checks++;
      if (!acc || data_out !== e || data_out !== 32'h200 + 32'(i)) begin
        $display("FAIL en_read[%0d] got=%h exp=%h", i, data_out, 32'h200 + 32'(i)); n_fail++;
      end
    end
    n_checks++;
    if (EMPTY !== 1'b1) begin $display("FAIL en_empty got=%b exp=1", EMPTY); n_fail++; end
  endtask

  task automatic test_async_reset();
    logic acc; logic [31:0] e;
    drive_cycle(1'b1, 1'b0, 1'b1, 32'h300, acc, e);
    drive_cycle(1'b1, 1'b0, 1'b1, 32'h301, acc, e);
    drive_cycle(1'b1, 1'b1, 1'b0, 32'h0, acc, e);
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if (EMPTY !== 1'b1 || FULL !== 1'b0 || data_out !== 32'h0) begin
      $display("FAIL async_reset got=%b/%b/%h exp=1/0/0", EMPTY, FULL, data_out); n_fail++;
    end
    sb.delete();
    model_count = 0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    drive_cycle(1'b1, 1'b0, 1'b1, 32'h5A, acc, e);
    drive_cycle(1'b1, 1'b1, 1'b0, 32'h0, acc, e);
    n_checks++;
    if (!acc || data_out !== e || data_out !== 32'h5A) begin
      $display("FAIL post_reset got=%h exp=5a", data_out); n_fail++;
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_basic_order();
    test_full();
    test_empty_read();
    test_simultaneous_wrap();
    test_enable_gating();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_sync_fifo
